pipe_ctrl_3stage: RTL and testbench

//  Sequencing/hazard controller for the 3-stage (IF/ID -> EXE -> WB) pipelined regfile datapath.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipe_ctrl_3stage_if.sv | 34 +++
 rtl/pipe_hazard_cmp.sv | 23 ++
 rtl/pipe_ctrl_3stage.sv | 141 ++++++++++++++
 tb/tb_pipe_ctrl_3stage.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 3-stage pipeline sequencing/hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  // Operand source mux encodings
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int AW_DEF = 4;

endpackage

// File: rtl/pipe_ctrl_3stage_if.sv
// Decode-side request and control-output bundle between the datapath and the pipeline controller.
interface pipe_ctrl_3stage_if #(
  parameter int AW    = 4,
  parameter int CNT_W = 16
);
  logic             start;
  logic             halt_dec;
  logic             id_ren1;
  logic [AW-1:0]    id_raddr1;
  logic             id_ren2;
  logic [AW-1:0]    id_raddr2;
  logic             id_wen;
  logic [AW-1:0]    id_waddr;
  logic             pc_en;
  logic             pc_clr;
  logic             bubble;
  logic             wb_we;
  logic [1:0]       fwd_sel1;
  logic [1:0]       fwd_sel2;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output start, halt_dec, id_ren1, id_raddr1, id_ren2, id_raddr2, id_wen, id_waddr,
    input  pc_en, pc_clr, bubble, wb_we, fwd_sel1, fwd_sel2, busy, done, stall_cnt
  );

  modport slave (
    input  start, halt_dec, id_ren1, id_raddr1, id_ren2, id_raddr2, id_wen, id_waddr,
    output pc_en, pc_clr, bubble, wb_we, fwd_sel1, fwd_sel2, busy, done, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_cmp.sv
// Compares one ID source operand against the in-flight EXE and WB destinations.
module pipe_hazard_cmp #(
  parameter int AW      = 4,
  parameter int R0_ZERO = 1
) (
  input  logic          ren,
  input  logic [AW-1:0] raddr,
  input  logic          exe_wen,
  input  logic [AW-1:0] exe_waddr,
  input  logic          wb_wen,
  input  logic [AW-1:0] wb_waddr,
  output logic          hit_exe,
  output logic          hit_wb
);

  logic is_r0;

  // r0 is hard-wired zero, so it can never carry a dependency
  assign is_r0   = (R0_ZERO != 0) && (raddr == '0);
  assign hit_exe = ren && !is_r0 && exe_wen && (exe_waddr == raddr);
  assign hit_wb  = ren && !is_r0 && wb_wen  && (wb_waddr  == raddr);

endmodule

// File: rtl/pipe_ctrl_3stage.sv
// Run/halt sequencing and RAW hazard control for the IF/ID -> EXE -> WB datapath.
// Define PIPE_CTRL_FWD_EN to resolve hazards by forwarding instead of stalling.
module pipe_ctrl_3stage
  import pipe_ctrl_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int CNT_W   = 16,
  parameter int R0_ZERO = 1
) (
  input  logic                clk,
  input  logic                rst,
  pipe_ctrl_3stage_if.slave   bus
);

  state_t           state, state_nx;
  logic             drain_cnt;
  logic             vld_p1, vld_p2;
  logic [AW-1:0]    waddr_p1, waddr_p2;
  logic [CNT_W-1:0] stall_cnt;
  logic             hit_exe1, hit_wb1, hit_exe2, hit_wb2;
  logic             hazard;
  logic             stall;
  logic             pc_en, pc_clr, bubble, busy, done;
  logic [1:0]       fwd_sel1, fwd_sel2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  pipe_hazard_cmp #(.AW(AW), .R0_ZERO(R0_ZERO)) u_cmp1 (
    .ren       (bus.id_ren1),
    .raddr     (bus.id_raddr1),
    .exe_wen   (vld_p1),
    .exe_waddr (waddr_p1),
    .wb_wen    (vld_p2),
    .wb_waddr  (waddr_p2),
    .hit_exe   (hit_exe1),
    .hit_wb    (hit_wb1)
  );

  pipe_hazard_cmp #(.AW(AW), .R0_ZERO(R0_ZERO)) u_cmp2 (
    .ren       (bus.id_ren2),
    .raddr     (bus.id_raddr2),
    .exe_wen   (vld_p1),
    .exe_waddr (waddr_p1),
    .wb_wen    (vld_p2),
    .wb_waddr  (waddr_p2),
    .hit_exe   (hit_exe2),
    .hit_wb    (hit_wb2)
  );

`ifdef PIPE_CTRL_FWD_EN
  assign hazard   = 1'b0;
  // EXE holds the younger write, so it wins over WB
  assign fwd_sel1 = hit_exe1 ? FWD_EXE : (hit_wb1 ? FWD_WB : FWD_REG);
  assign fwd_sel2 = hit_exe2 ? FWD_EXE : (hit_wb2 ? FWD_WB : FWD_REG);
`else
  assign hazard   = hit_exe1 | hit_wb1 | hit_exe2 | hit_wb2;
  assign fwd_sel1 = FWD_REG;
  assign fwd_sel2 = FWD_REG;
`endif

  always_comb begin
    state_nx = state;
    pc_en    = 1'b0;
    pc_clr   = 1'b0;
    bubble   = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = RUN;
          pc_clr   = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (bus.halt_dec) begin
          state_nx = DRAIN;
        end else if (hazard) begin
          stall = 1'b1;
        end else begin
          pc_en  = 1'b1;
          bubble = 1'b0;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt) state_nx = HALTED;
      end
      HALTED: begin
        done = 1'b1;
        if (bus.start) begin
          state_nx = RUN;
          pc_clr   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (rst) pc_clr = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nx;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      // ID -> EXE: a bubble retires the write intent
      vld_p1    <= bubble ? 1'b0 : bus.id_wen;
      // EXE -> WB
      vld_p2    <= vld_p1;
      if (pc_clr)     stall_cnt <= '0;
      else if (stall) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  always_ff @(posedge clk) begin
    // ID -> EXE
    waddr_p1 <= bubble ? '0 : bus.id_waddr;
    // EXE -> WB
    waddr_p2 <= waddr_p1;
  end

  assign bus.pc_en     = pc_en;
  assign bus.pc_clr    = pc_clr;
  assign bus.bubble    = bubble;
  assign bus.wb_we     = vld_p2;
  assign bus.fwd_sel1  = fwd_sel1;
  assign bus.fwd_sel2  = fwd_sel2;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl_3stage.sv
// Directed bench for pipe_ctrl_3stage; expectations follow PIPE_CTRL_FWD_EN when defined.
module tb_pipe_ctrl_3stage;

  localparam int AW    = 4;
  localparam int CNT_W = 16;
`ifdef PIPE_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pipe_ctrl_3stage_if #(.AW(AW), .CNT_W(CNT_W)) bus ();

  pipe_ctrl_3stage #(.AW(AW), .CNT_W(CNT_W), .R0_ZERO(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {pc_en, pc_clr, bubble, wb_we, busy, done}
  logic [5:0] ctl;
  logic [3:0] fwd;
  assign ctl = {bus.pc_en, bus.pc_clr, bus.bubble, bus.wb_we, bus.busy, bus.done};
  assign fwd = {bus.fwd_sel1, bus.fwd_sel2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic id(input logic r1, input logic [AW-1:0] a1, input logic r2,
                    input logic [AW-1:0] a2, input logic w, input logic [AW-1:0] wa);
    bus.id_ren1 = r1; bus.id_raddr1 = a1;
    bus.id_ren2 = r2; bus.id_raddr2 = a2;
    bus.id_wen  = w;  bus.id_waddr  = wa;
  endtask

  task automatic nop();
    id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.halt_dec = 1'b0; nop();
    cyc(); cyc();
    rst = 1'b0; bus.start = 1'b1; #1;
    if (ctl !== 6'b011000) begin $display("FAIL reset_start_ctl got=%b exp=%b", ctl, 6'b011000); errors++; end
    checks++;
    if (bus.stall_cnt !== 16'd0) begin $display("FAIL reset_stall_cnt got=%0d exp=0", bus.stall_cnt); errors++; end
    checks++;
    cyc(); bus.start = 1'b0; #1;
    if (ctl !== 6'b100010) begin $display("FAIL reset_run_ctl got=%b exp=%b", ctl, 6'b100010); errors++; end
    checks++;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0; #1;
    if (ctl !== 6'b001000) begin $display("FAIL reset_in_run_ctl got=%b exp=%b", ctl, 6'b001000); errors++; end
    checks++;
    if ({fwd, bus.stall_cnt} !== 20'd0) begin $display("FAIL reset_fwd_cnt got=%h exp=0", {fwd, bus.stall_cnt}); errors++; end
    checks++;
  endtask

  task automatic test_issue();
    cyc(); bus.start = 1'b1; nop(); #1;
    if (ctl !== 6'b011000) begin $display("FAIL issue_start got=%b exp=%b", ctl, 6'b011000); errors++; end
    checks++;
    cyc(); bus.start = 1'b0; id(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd1); #1;
    if (ctl !== 6'b100010) begin $display("FAIL issue_i0 got=%b exp=%b", ctl, 6'b100010); errors++; end
    checks++;
    cyc(); bus.start = 1'b1; id(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 4'd4); #1;
    if (ctl !== 6'b100010) begin $display("FAIL issue_i1_start_ignored got=%b exp=%b", ctl, 6'b100010); errors++; end
    checks++;
    cyc(); bus.start = 1'b0; nop(); #1;
    if (ctl !== 6'b100110) begin $display("FAIL issue_wb_i0 got=%b exp=%b", ctl, 6'b100110); errors++; end
    checks++;
    cyc(); #1;
    if (ctl !== 6'b100110) begin $display("FAIL issue_wb_i1 got=%b exp=%b", ctl, 6'b100110); errors++; end
    checks++;
    cyc(); #1;
    if (ctl !== 6'b100010) begin $display("FAIL issue_wb_idle got=%b exp=%b", ctl, 6'b100010); errors++; end
    checks++;
    if (bus.stall_cnt !== 16'd0) begin $display("FAIL issue_stall_cnt got=%0d exp=0", bus.stall_cnt); errors++; end
    checks++;
  endtask

  task automatic test_raw_exe();
    cyc(); id(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd3); #1;
    if (ctl !== 6'b100010) begin $display("FAIL rawexe_i0 got=%b exp=%b", ctl, 6'b100010); errors++; end
    checks++;
    cyc(); id(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0); #1;
    if (ctl !== (FWD ? 6'b100010 : 6'b001010)) begin $display("FAIL rawexe_c1_ctl got=%b exp=%b", ctl, FWD ? 6'b100010 : 6'b001010); errors++; end
    checks++;
    if (fwd !== (FWD ? 4'b0100 : 4'b0000)) begin $display("FAIL rawexe_c1_fwd got=%b exp=%b", fwd, FWD ? 4'b0100 : 4'b0000); errors++; end
    checks++;
    cyc(); if (FWD) nop(); #1;
    if (ctl !== (FWD ? 6'b100110 : 6'b001110)) begin $display("FAIL rawexe_c2_ctl got=%b exp=%b", ctl, FWD ? 6'b100110 : 6'b001110); errors++; end
    checks++;
    cyc(); #1;
    if (ctl !== 6'b100010) begin $display("FAIL rawexe_c3_ctl got=%b exp=%b", ctl, 6'b100010); errors++; end
    checks++;
    if (bus.stall_cnt !== (FWD ? 16'd0 : 16'd2)) begin $display("FAIL rawexe_stall_cnt got=%0d exp=%0d", bus.stall_cnt, FWD ? 0 : 2); errors++; end
    checks++;
    cyc(); nop();
  endtask

  task automatic test_raw_wb();
    cyc(); id(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd3); #1;
    if (ctl !== 6'b100010) begin $display("FAIL rawwb_i0 got=%b exp=%b", ctl, 6'b100010); errors++; end
    checks++;
    cyc(); nop();
    cyc(); id(1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 4'd0); #1;
    if (ctl !== (FWD ? 6'b100110 : 6'b001110)) begin $display("FAIL rawwb_c1_ctl got=%b exp=%b", ctl, FWD ? 6'b100110 : 6'b001110); errors++; end
    checks++;
    if (fwd !== (FWD ? 4'b0010 : 4'b0000)) begin $display("FAIL rawwb_c1_fwd got=%b exp=%b", fwd, FWD ? 4'b0010 : 4'b0000); errors++; end
    checks++;
    cyc(); if (FWD) nop(); #1;
    if (ctl !== 6'b100010) begin $display("FAIL rawwb_c2_ctl got=%b exp=%b", ctl, 6'b100010); errors++; end
    checks++;
    if (bus.stall_cnt !== (FWD ? 16'd0 : 16'd3)) begin $display("FAIL rawwb_stall_cnt got=%0d exp=%0d", bus.stall_cnt, FWD ? 0 : 3); errors++; end
    checks++;
    cyc(); nop();
  endtask

  task automatic test_r0();
    cyc(); id(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd0);
    cyc(); id(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0); #1;
    if ({ctl, fwd} !== {6'b100010, 4'b0000}) begin $display("FAIL r0_exe got=%b exp=%b", {ctl, fwd}, {6'b100010, 4'b0000}); errors++; end
    checks++;
    cyc(); id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0); #1;
    if ({ctl, fwd} !== {6'b100110, 4'b0000}) begin $display("FAIL r0_wb got=%b exp=%b", {ctl, fwd}, {6'b100110, 4'b0000}); errors++; end
    checks++;
    cyc(); nop(); #1;
    if (bus.stall_cnt !== (FWD ? 16'd0 : 16'd3)) begin $display("FAIL r0_stall_cnt got=%0d exp=%0d", bus.stall_cnt, FWD ? 0 : 3); errors++; end
    checks++;
  endtask

  task automatic test_halt();
    cyc(); bus.halt_dec = 1'b1; #1;
    if (ctl !== 6'b001010) begin $display("FAIL halt_run got=%b exp=%b", ctl, 6'b001010); errors++; end
    checks++;
    cyc(); bus.halt_dec = 1'b0; #1;
    if (ctl !== 6'b001010) begin $display("FAIL halt_drain1 got=%b exp=%b", ctl, 6'b001010); errors++; end
    checks++;
    cyc(); #1;
    if (ctl !== 6'b001010) begin $display("FAIL halt_drain2 got=%b exp=%b", ctl, 6'b001010); errors++; end
    checks++;
    cyc(); #1;
    if (ctl !== 6'b001001) begin $display("FAIL halt_done got=%b exp=%b", ctl, 6'b001001); errors++; end
    checks++;
    cyc(); bus.start = 1'b1; #1;
    if (ctl !== 6'b011001) begin $display("FAIL halt_restart got=%b exp=%b", ctl, 6'b011001); errors++; end
    checks++;
    cyc(); bus.start = 1'b0; #1;
    if ({ctl, bus.stall_cnt} !== {6'b100010, 16'd0}) begin $display("FAIL halt_rerun got=%h exp=%h", {ctl, bus.stall_cnt}, {6'b100010, 16'd0}); errors++; end
    checks++;
    id(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd7);
    // halt with a pending EXE hazard: drains without counting a stall
    cyc(); bus.halt_dec = 1'b1; id(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 4'd0); #1;
    if (ctl !== 6'b001010) begin $display("FAIL halt_over_hazard got=%b exp=%b", ctl, 6'b001010); errors++; end
    checks++;
    cyc(); bus.halt_dec = 1'b0; nop(); #1;
    if ({ctl, bus.stall_cnt} !== {6'b001110, 16'd0}) begin $display("FAIL halt_drain_wb got=%h exp=%h", {ctl, bus.stall_cnt}, {6'b001110, 16'd0}); errors++; end
    checks++;
    rst = 1'b1;
    cyc(); rst = 1'b0; #1;
    if (ctl !== 6'b001000) begin $display("FAIL rst_in_drain got=%b exp=%b", ctl, 6'b001000); errors++; end
    checks++;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_issue();
    test_raw_exe();
    test_raw_wb();
    test_r0();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
